// File: rtl/alu_seq.sv
// alu_seq -- execute-stage ALU with handshake, registered CCR and an
// optional sequential shift-add multiplier.
//
// Build option: define ALU_MUL_EN to include the MUL opcode (10) and its
// multi-cycle FSM. Without it, opcode 10 is a reserved 1-cycle op, busy and
// result_hi are tied to 0, and in_ready is constant 1.
//
// Ports
//   clk, rst_n        clock, asynchronous active-low reset
//   in_valid/in_ready request handshake; in_ready = !busy
//   op, dst, src      opcode and operands
//   flag_wen          let this op's flags load the CCR on completion
//   ccr_wr/ccr_wdata  direct CCR load; beats a same-edge flag update
//   result/result_hi  registered result (low/high half of the MUL product)
//   out_valid         one-cycle pulse per completed op
//   ccr               {C,V,N,Z}
//   busy              multiplier running
module alu_seq #(
  parameter int WIDTH   = 16,
  parameter int SHAMT_W = $clog2(WIDTH) + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       op,
  input  logic [WIDTH-1:0] src,
  input  logic [WIDTH-1:0] dst,
  input  logic             flag_wen,
  input  logic             ccr_wr,
  input  logic [3:0]       ccr_wdata,
  output logic [WIDTH-1:0] result,
  output logic [WIDTH-1:0] result_hi,
  output logic             out_valid,
  output logic [3:0]       ccr,
  output logic             busy
);

  localparam int MSB = WIDTH - 1;

  localparam logic [3:0] OP_NOP = 4'd0;
  localparam logic [3:0] OP_ADD = 4'd1;
  localparam logic [3:0] OP_SUB = 4'd2;
  localparam logic [3:0] OP_AND = 4'd3;
  localparam logic [3:0] OP_OR  = 4'd4;
  localparam logic [3:0] OP_NOT = 4'd5;
  localparam logic [3:0] OP_INC = 4'd6;
  localparam logic [3:0] OP_DEC = 4'd7;
  localparam logic [3:0] OP_SHL = 4'd8;
  localparam logic [3:0] OP_SHR = 4'd9;
`ifdef ALU_MUL_EN
  localparam logic [3:0] OP_MUL = 4'd10;
`endif

  logic accept;
  assign accept = in_valid && in_ready;

  // ---------------- single-cycle datapath ----------------
  logic [SHAMT_W-1:0] amt;
  logic [WIDTH-1:0]   opb;
  logic [WIDTH:0]     wide;
  logic [WIDTH-1:0]   ex_res;
  logic               ex_c, ex_v, ex_upd;
  logic [3:0]         ex_flags;

  assign amt = src[SHAMT_W-1:0];
  // INC/DEC reuse the adder/subtractor with a constant 1 operand
  assign opb = (op == OP_INC || op == OP_DEC) ? WIDTH'(1) : src;

  always_comb begin
    ex_res = '0;
    ex_c   = 1'b0;
    ex_v   = 1'b0;
    ex_upd = 1'b1;
    wide   = '0;
    case (op)
      OP_NOP: begin
        ex_res = dst;
        ex_upd = 1'b0;
      end
      OP_ADD, OP_INC: begin
        wide   = {1'b0, dst} + {1'b0, opb};
        ex_res = wide[MSB:0];
        ex_c   = wide[WIDTH];
        ex_v   = (dst[MSB] == opb[MSB]) && (ex_res[MSB] != dst[MSB]);
      end
      OP_SUB, OP_DEC: begin
        // bit WIDTH of the extended difference is the borrow
        wide   = {1'b0, dst} - {1'b0, opb};
        ex_res = wide[MSB:0];
        ex_c   = wide[WIDTH];
        ex_v   = (dst[MSB] != opb[MSB]) && (ex_res[MSB] != dst[MSB]);
      end
      OP_AND: ex_res = dst & src;
      OP_OR:  ex_res = dst | src;
      OP_NOT: ex_res = ~dst;
      OP_SHL, OP_SHR: begin
        if (amt == '0) begin
          ex_res = dst;
        end else if (32'(amt) >= WIDTH) begin
          ex_res = '0;
        end else if (op == OP_SHL) begin
          // extra top bit catches the last bit shifted out
          wide   = {1'b0, dst} << amt;
          ex_res = wide[MSB:0];
          ex_c   = wide[WIDTH];
        end else begin
          wide   = {dst, 1'b0} >> amt;
          ex_res = wide[WIDTH:1];
          ex_c   = wide[0];
        end
      end
      default: begin
        ex_res = '0;
        ex_upd = 1'b0;
      end
    endcase
  end

  assign ex_flags = {ex_c, ex_v, ex_res[MSB], (ex_res == '0)};

  // ---------------- multiplier ----------------
  logic                 start_mul;
  logic                 mul_last;
  logic                 mul_fwen;
  logic [2*WIDTH-1:0]   acc_nxt;
  logic [3:0]           mul_flags;

`ifdef ALU_MUL_EN
  localparam int CNT_W = $clog2(WIDTH);

  typedef enum logic {S_IDLE, S_MUL} state_t;
  state_t state, state_nxt;

  logic [2*WIDTH-1:0] mcand;
  logic [WIDTH-1:0]   mplier;
  logic [2*WIDTH-1:0] acc;
  logic [CNT_W-1:0]   cnt;
  logic [WIDTH-1:0]   mul_hi;

  assign start_mul = accept && (op == OP_MUL);
  assign mul_last  = (state == S_MUL) && (cnt == CNT_W'(WIDTH - 1));
  assign busy      = (state == S_MUL);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (start_mul) state_nxt = S_MUL;
      S_MUL:   if (mul_last)  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // one partial product per cycle; the final step's sum is the product
  assign acc_nxt   = acc + (mplier[0] ? mcand : '0);
  assign mul_hi    = acc_nxt[2*WIDTH-1:WIDTH];
  assign mul_flags = {(|mul_hi), (|mul_hi), acc_nxt[MSB], (acc_nxt == '0)};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mcand    <= '0;
      mplier   <= '0;
      acc      <= '0;
      cnt      <= '0;
      mul_fwen <= 1'b0;
    end else if (start_mul) begin
      mcand    <= {{WIDTH{1'b0}}, dst};
      mplier   <= src;
      acc      <= '0;
      cnt      <= '0;
      mul_fwen <= flag_wen;
    end else if (state == S_MUL) begin
      acc    <= acc_nxt;
      mcand  <= {mcand[2*WIDTH-2:0], 1'b0};
      mplier <= {1'b0, mplier[MSB:1]};
      cnt    <= cnt + 1'b1;
    end
  end
`else
  assign start_mul = 1'b0;
  assign mul_last  = 1'b0;
  assign mul_fwen  = 1'b0;
  assign acc_nxt   = '0;
  assign mul_flags = 4'h0;
  assign busy      = 1'b0;
`endif

  assign in_ready = !busy;

  // ---------------- result / CCR registers ----------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      result    <= '0;
      result_hi <= '0;
      out_valid <= 1'b0;
      ccr       <= 4'h0;
    end else begin
      out_valid <= 1'b0;
      if (mul_last) begin
        result    <= acc_nxt[MSB:0];
        result_hi <= acc_nxt[2*WIDTH-1:WIDTH];
        out_valid <= 1'b1;
        if (mul_fwen) ccr <= mul_flags;
      end else if (accept && !start_mul) begin
        result    <= ex_res;
        result_hi <= '0;
        out_valid <= 1'b1;
        if (flag_wen && ex_upd) ccr <= ex_flags;
      end
      // direct load overrides any same-edge flag update
      if (ccr_wr) ccr <= ccr_wdata;
    end
  end

endmodule

// File: tb/tb_alu_seq.sv
// tb_alu_seq -- scoreboard bench for alu_seq (WIDTH=16).
// Driver pushes expected completions (from a behavioural model) into a
// queue; a negedge monitor pops them when due and compares every output.
module tb_alu_seq;
  localparam int W  = 16;
  localparam int SW = $clog2(W) + 1;
`ifdef ALU_MUL_EN
  localparam bit MUL_EN = 1'b1;
`else
  localparam bit MUL_EN = 1'b0;
`endif
  localparam longint SMAX = (longint'(1) << (W - 1)) - 1;
  localparam longint SMIN = -(longint'(1) << (W - 1));

  logic         clk = 1'b0;
  logic         rst_n = 1'b1;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [3:0]   op = 4'h0;
  logic [W-1:0] src = '0, dst = '0;
  logic         flag_wen = 1'b0, ccr_wr = 1'b0;
  logic [3:0]   ccr_wdata = 4'h0;
  logic [W-1:0] result, result_hi;
  logic         out_valid, busy;
  logic [3:0]   ccr;

  alu_seq #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .op(op), .src(src), .dst(dst), .flag_wen(flag_wen), .ccr_wr(ccr_wr),
    .ccr_wdata(ccr_wdata), .result(result), .result_hi(result_hi),
    .out_valid(out_valid), .ccr(ccr), .busy(busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [W-1:0] res, hi;
    logic [3:0]   flags;
    bit           upd, fwen;
    int           lat, done;
  } exp_t;
  typedef struct { int cyc; logic [3:0] d; } cw_t;

  exp_t         expq[$];
  cw_t          cwq[$];
  int           errors = 0, checks = 0;
  int           busy_until = 0;
  bit           in_rst = 1'b1;
  logic [3:0]   m_ccr = 4'h0;
  logic [W-1:0] m_res = '0, m_hi = '0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s @cyc %0d: got %0h expected %0h", name, cyc, act, exp);
    end
  endtask

  // Reference model straight from the opcode table, using integer arithmetic.
  function automatic exp_t ref_op(input logic [3:0] o, input logic [W-1:0] d,
                                  input logic [W-1:0] s, input bit fw);
    exp_t e;
    longint ud, us, sd, ss, r;
    logic [SW-1:0] a;
    int amt;
    bit c, v, z;
    ud = longint'(d); us = longint'(s);
    sd = longint'($signed(d)); ss = longint'($signed(s));
    a = s[SW-1:0]; amt = int'(a);
    e.res = '0; e.hi = '0; e.upd = 1'b1; e.fwen = fw; e.lat = 1; e.done = 0;
    c = 1'b0; v = 1'b0; r = 0;
    case (o)
      4'd0: begin e.res = d; e.upd = 1'b0; end
      4'd1, 4'd6: begin
        if (o == 4'd6) begin us = 1; ss = 1; end
        r = ud + us; e.res = W'(r);
        c = (r >= (longint'(1) << W));
        v = ((sd + ss) > SMAX) || ((sd + ss) < SMIN);
      end
      4'd2, 4'd7: begin
        if (o == 4'd7) begin us = 1; ss = 1; end
        r = ud - us; e.res = W'(r);
        c = (ud < us);
        v = ((sd - ss) > SMAX) || ((sd - ss) < SMIN);
      end
      4'd3: e.res = d & s;
      4'd4: e.res = d | s;
      4'd5: e.res = ~d;
      4'd8: if (amt < W) begin
        e.res = W'(ud << amt);
        c = (amt > 0) && (((ud >> (W - amt)) & 1) != 0);
      end
      4'd9: if (amt < W) begin
        e.res = W'(ud >> amt);
        c = (amt > 0) && (((ud >> (amt - 1)) & 1) != 0);
      end
      4'd10: if (MUL_EN) begin
        r = ud * us; e.res = W'(r); e.hi = W'(r >> W);
        c = (e.hi != 0); v = c; e.lat = W + 1;
      end else e.upd = 1'b0;
      default: e.upd = 1'b0;
    endcase
    z = (o == 4'd10 && MUL_EN) ? (r == 0) : (e.res == 0);
    e.flags = {c, v, e.res[W-1], z};
    return e;
  endfunction

  // Monitor: expected state advances per edge, then every output is compared.
  always @(negedge clk) begin
    if (!in_rst) begin
      exp_t e;
      cw_t  w;
      bit   ov;
      ov = 1'b0;
      chk("in_ready", 64'(in_ready), 64'(cyc >= busy_until));
      chk("busy", 64'(busy), 64'(cyc < busy_until));
      if (expq.size() > 0 && expq[0].done == cyc) begin
        e = expq.pop_front();
        ov = 1'b1; m_res = e.res; m_hi = e.hi;
        if (e.upd && e.fwen) m_ccr = e.flags;
      end
      if (cwq.size() > 0 && cwq[0].cyc == cyc) begin
        w = cwq.pop_front();
        m_ccr = w.d;
      end
      chk("out_valid", 64'(out_valid), 64'(ov));
      chk("result", 64'(result), 64'(m_res));
      chk("result_hi", 64'(result_hi), 64'(m_hi));
      chk("ccr", 64'(ccr), 64'(m_ccr));
    end
  end

  // Issue one request, holding it while the model says the DUT is busy.
  task automatic issue(input logic [3:0] o, input logic [W-1:0] d, input logic [W-1:0] s,
                       input bit fw, input bit cw = 1'b0, input logic [3:0] cwd = 4'h0);
    exp_t e;
    cw_t  w;
    @(negedge clk); #1;
    in_valid = 1'b1; op = o; dst = d; src = s; flag_wen = fw; ccr_wr = 1'b0;
    while (cyc < busy_until) begin
      @(negedge clk); #1;
    end
    if (cw) begin
      ccr_wr = 1'b1; ccr_wdata = cwd;
      w.cyc = cyc + 1; w.d = cwd; cwq.push_back(w);
    end
    e = ref_op(o, d, s, fw);
    e.done = cyc + e.lat;
    if (e.lat > 1) busy_until = cyc + 1 + W;
    expq.push_back(e);
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk); #1;
      in_valid = 1'b0; ccr_wr = 1'b0;
    end
  endtask

  task automatic ccr_load(input logic [3:0] d);
    cw_t w;
    @(negedge clk); #1;
    in_valid = 1'b0; ccr_wr = 1'b1; ccr_wdata = d;
    w.cyc = cyc + 1; w.d = d; cwq.push_back(w);
  endtask

  task automatic reset_check();
    @(negedge clk); #2;
    in_rst = 1'b1; rst_n = 1'b0; in_valid = 1'b0; ccr_wr = 1'b0;
    #1;
    chk("rst result", 64'(result), 64'(0));
    chk("rst result_hi", 64'(result_hi), 64'(0));
    chk("rst out_valid", 64'(out_valid), 64'(0));
    chk("rst ccr", 64'(ccr), 64'(0));
    chk("rst busy", 64'(busy), 64'(0));
    chk("rst in_ready", 64'(in_ready), 64'(1));
    expq.delete(); cwq.delete();
    m_ccr = 4'h0; m_res = '0; m_hi = '0; busy_until = 0;
    @(negedge clk); #1;
    rst_n = 1'b1; in_rst = 1'b0;
  endtask

  function automatic logic [W-1:0] pick();
    case ($urandom_range(0, 5))
      0: return '0;
      1: return '1;
      2: return 16'h7FFF;
      3: return 16'h8000;
      default: return W'($urandom);
    endcase
  endfunction

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [3:0]   o;
    logic [W-1:0] d, s;
    #1 rst_n = 1'b0;
    #1;
    chk("init in_ready", 64'(in_ready), 64'(1));
    chk("init out_valid", 64'(out_valid), 64'(0));
    chk("init ccr", 64'(ccr), 64'(0));
    @(negedge clk); #1;
    rst_n = 1'b1; in_rst = 1'b0;

    issue(4'd1, 16'h7FFF, 16'h0001, 1'b1);
    issue(4'd1, 16'h7FFF, 16'h0001, 1'b0);
    issue(4'd2, 16'h0005, 16'h0005, 1'b1);
    issue(4'd7, 16'h0000, 16'h0000, 1'b1);
    issue(4'd10, 16'h1234, 16'h0100, 1'b1);
    issue(4'd1, 16'h0003, 16'h0004, 1'b1);   // held while busy
    issue(4'd10, 16'hFFFF, 16'hFFFF, 1'b1);
    ccr_load(4'h5);                          // direct load during busy
    idle(2);
    issue(4'd8, 16'h8001, 16'd1, 1'b1);
    issue(4'd8, 16'h1234, 16'd16, 1'b1);
    issue(4'd9, 16'h0001, 16'd1, 1'b1);
    issue(4'd1, 16'h0001, 16'h0001, 1'b1, 1'b1, 4'b1010);
    issue(4'd12, 16'hFFFF, 16'hFFFF, 1'b1);
    idle(2);

    issue(4'd10, 16'h00FF, 16'h0F0F, 1'b1);
    idle(5);
    reset_check();                           // abort mid-MUL
    idle(W + 3);

    for (int i = 0; i < 400; i++) begin
      o = 4'($urandom_range(0, 15));
      d = pick();
      s = (o == 4'd8 || o == 4'd9) ? W'($urandom_range(0, 31)) : pick();
      case ($urandom_range(0, 19))
        0: idle(int'($urandom_range(1, 3)));
        1: ccr_load(4'($urandom_range(0, 15)));
        default: issue(o, d, s, 1'($urandom_range(0, 1)),
                       ($urandom_range(0, 9) == 0), 4'($urandom_range(0, 15)));
      endcase
    end
    idle(W + 4);
    chk("drain", 64'(expq.size()), 64'(0));
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
